// File: rtl/strv32i_pkg.sv
// Shared STRV32I definitions: RV32I major opcodes, immediate-type codes,
// the canonical NOP and the IF/ID skid-buffer state encoding.
package strv32i_pkg;

    // RV32I major opcodes (inst[6:0])
    localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
    localparam logic [6:0] OPC_OPIMM  = 7'b001_0011;
    localparam logic [6:0] OPC_JALR   = 7'b110_0111;
    localparam logic [6:0] OPC_STORE  = 7'b010_0011;
    localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
    localparam logic [6:0] OPC_LUI    = 7'b011_0111;
    localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
    localparam logic [6:0] OPC_JAL    = 7'b110_1111;
    localparam logic [6:0] OPC_SYSTEM = 7'b111_0011;
    localparam logic [6:0] OPC_OP     = 7'b011_0011;

    // Immediate-type codes consumed by the immediate generator
    localparam logic [2:0] IMM_NONE = 3'b000;
    localparam logic [2:0] IMM_I    = 3'b001;
    localparam logic [2:0] IMM_S    = 3'b010;
    localparam logic [2:0] IMM_B    = 3'b011;
    localparam logic [2:0] IMM_U    = 3'b100;
    localparam logic [2:0] IMM_J    = 3'b101;
    localparam logic [2:0] IMM_CSR  = 3'b111;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // Occupancy of the OUT/SKID pair
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } ifid_state_e;

    // True when the opcode is one the core implements (implies opc[1:0]==2'b11)
    function automatic logic opcode_known(input logic [6:0] opc);
        logic known;
        case (opc)
            OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_STORE, OPC_BRANCH,
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_SYSTEM, OPC_OP: known = 1'b1;
            default:                                         known = 1'b0;
        endcase
        return known;
    endfunction

endpackage : strv32i_pkg

// File: rtl/imm_type_decoder.sv
// Combinational pre-decode of inst[6:0] into the 3-bit immediate-type code.
// With IF_ID_ILLEGAL_CHK_EN defined, an illegal flag is also produced for
// opcodes outside the implemented set; otherwise that port does not exist.
module imm_type_decoder
    import strv32i_pkg::*;
(
    input  logic [6:0] opcode,
`ifdef IF_ID_ILLEGAL_CHK_EN
    output logic       illegal,
`endif
    output logic [2:0] imm_type
);

    // Map the major opcode onto its immediate format; unknowns give IMM_NONE
    always_comb begin
        imm_type = IMM_NONE;
        case (opcode)
            OPC_LOAD, OPC_OPIMM, OPC_JALR: imm_type = IMM_I;
            OPC_STORE:                     imm_type = IMM_S;
            OPC_BRANCH:                    imm_type = IMM_B;
            OPC_LUI, OPC_AUIPC:            imm_type = IMM_U;
            OPC_JAL:                       imm_type = IMM_J;
            OPC_SYSTEM:                    imm_type = IMM_CSR;
            OPC_OP:                        imm_type = IMM_NONE;
            default:                       imm_type = IMM_NONE;
        endcase
    end

`ifdef IF_ID_ILLEGAL_CHK_EN
    // Unknown opcode (including any with opcode[1:0] != 2'b11) is illegal
    always_comb begin
        illegal = ~opcode_known(opcode);
    end
`endif

endmodule : imm_type_decoder

// File: rtl/if_id_decode_reg.sv
// IF/ID pipeline boundary: 2-entry skid buffer (OUT + SKID) between fetch and
// decode, with opcode pre-decode registered alongside each instruction.
// Optional macro IF_ID_ILLEGAL_CHK_EN adds a registered illegal-opcode flag;
// when undefined illegal_out is tied low and no check logic is built.
module if_id_decode_reg
    import strv32i_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic [31:0]     inst_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic            valid_in,
    output logic            ready_out,
    input  logic            flush_in,
    output logic [31:0]     inst_out,
    output logic [XLEN-1:0] pc_out,
    output logic [2:0]      imm_type_out,
    output logic            valid_out,
    input  logic            ready_in,
    output logic            illegal_out
);

    ifid_state_e     state_r;
    ifid_state_e     state_nxt_s;
    logic            valid_r;
    logic            ready_r;

    logic [31:0]     out_inst_r;
    logic [XLEN-1:0] out_pc_r;
    logic [2:0]      out_imm_r;
    logic [31:0]     skid_inst_r;
    logic [XLEN-1:0] skid_pc_r;
    logic [2:0]      skid_imm_r;

    logic [2:0]      dec_imm_s;
    logic            accept_s;
    logic            drain_s;
    logic            load_out_in_s;
    logic            load_out_skid_s;
    logic            load_skid_in_s;

    // Pre-decode on the input path so the type is registered with the word
`ifdef IF_ID_ILLEGAL_CHK_EN
    logic            dec_ill_s;
    logic            out_ill_r;
    logic            skid_ill_r;

    imm_type_decoder u_dec (
        .opcode   (inst_in[6:0]),
        .illegal  (dec_ill_s),
        .imm_type (dec_imm_s)
    );
`else
    imm_type_decoder u_dec (
        .opcode   (inst_in[6:0]),
        .imm_type (dec_imm_s)
    );
`endif

    // Handshake qualifiers, both taken from registered flags
    always_comb begin
        accept_s = valid_in & ready_r;
        drain_s  = valid_r & ready_in;
    end

    // Next occupancy and which register loads from where; flush wins
    always_comb begin
        state_nxt_s     = state_r;
        load_out_in_s   = 1'b0;
        load_out_skid_s = 1'b0;
        load_skid_in_s  = 1'b0;
        if (flush_in) begin
            state_nxt_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_nxt_s   = ST_ONE;
                        load_out_in_s = 1'b1;
                    end else begin
                        state_nxt_s   = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && drain_s) begin
                        state_nxt_s    = ST_ONE;
                        load_out_in_s  = 1'b1;
                    end else if (accept_s) begin
                        state_nxt_s    = ST_TWO;
                        load_skid_in_s = 1'b1;
                    end else if (drain_s) begin
                        state_nxt_s    = ST_EMPTY;
                    end else begin
                        state_nxt_s    = ST_ONE;
                    end
                end
                ST_TWO: begin
                    // ready_out is low here, so no accept can coincide
                    if (drain_s) begin
                        state_nxt_s     = ST_ONE;
                        load_out_skid_s = 1'b1;
                    end else begin
                        state_nxt_s     = ST_TWO;
                    end
                end
                default: begin
                    state_nxt_s = ST_EMPTY;
                end
            endcase
        end
    end

    // Control registers: occupancy, registered valid_out and ready_out
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_r <= ST_EMPTY;
            valid_r <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            valid_r <= (state_nxt_s != ST_EMPTY);
            ready_r <= (state_nxt_s != ST_TWO);
        end
    end

    // OUT register: loads from input or SKID, otherwise holds (also on flush)
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            out_inst_r <= NOP_INST;
            out_pc_r   <= RESET_PC;
            out_imm_r  <= IMM_I;
        end else if (load_out_in_s) begin
            out_inst_r <= inst_in;
            out_pc_r   <= pc_in;
            out_imm_r  <= dec_imm_s;
        end else if (load_out_skid_s) begin
            out_inst_r <= skid_inst_r;
            out_pc_r   <= skid_pc_r;
            out_imm_r  <= skid_imm_r;
        end
    end

    // SKID register: captures input when OUT is stalled
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            skid_inst_r <= NOP_INST;
            skid_pc_r   <= RESET_PC;
            skid_imm_r  <= IMM_I;
        end else if (load_skid_in_s) begin
            skid_inst_r <= inst_in;
            skid_pc_r   <= pc_in;
            skid_imm_r  <= dec_imm_s;
        end
    end

`ifdef IF_ID_ILLEGAL_CHK_EN
    // Illegal flag travels through OUT/SKID exactly like the other fields
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            out_ill_r  <= 1'b0;
            skid_ill_r <= 1'b0;
        end else begin
            if (load_out_in_s) begin
                out_ill_r <= dec_ill_s;
            end else if (load_out_skid_s) begin
                out_ill_r <= skid_ill_r;
            end
            if (load_skid_in_s) begin
                skid_ill_r <= dec_ill_s;
            end
        end
    end

    assign illegal_out = out_ill_r;
`else
    assign illegal_out = 1'b0;
`endif

    assign ready_out    = ready_r;
    assign valid_out    = valid_r;
    assign inst_out     = out_inst_r;
    assign pc_out       = out_pc_r;
    assign imm_type_out = out_imm_r;

endmodule : if_id_decode_reg
